if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined RISC-V core.
- Owns the program counter and drives the address of the combinational instruction ROM.
- Captures the returned word into the IF/ID pipeline register.
- Handles decode-stage stalls, branch/jump redirects, and halt-on-zero-word (end of program image).

---
 rtl/if_fetch_stage.sv | 92 +++++++++
 tb/tb_if_fetch_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, drives the ROM address, fills IF/ID.
// Ports: clk/rst_n, stall, redirect_valid/pc, imem_addr/rdata, IF/ID, halted, fetch_count.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               if_id_valid,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_pc_plus4,
    output logic [31:0]        if_id_instr,
    output logic               halted,
    output logic [COUNT_W-1:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        do_redir;
    logic        do_hold;
    logic        do_idle;
    logic        do_halt;
    logic        do_fetch;
    logic        load_bubble;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // One-hot edge action: redirect > stall > halted > normal.
    always_comb begin
        do_redir = redirect_valid;
        do_hold  = !redirect_valid && stall;
        do_idle  = !redirect_valid && !stall && halted;
        do_halt  = !redirect_valid && !stall && !halted
                   && (imem_rdata == 32'h0);
        do_fetch = !redirect_valid && !stall && !halted
                   && (imem_rdata != 32'h0);
        load_bubble = do_redir || do_idle || do_halt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else begin
            unique case (1'b1)
                do_redir: begin
                    pc     <= {redirect_pc[31:2], 2'b00};
                    halted <= 1'b0;
                end
                do_halt:  halted <= 1'b1;
                do_fetch: pc     <= pc_plus4;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid    <= 1'b0;
            if_id_pc       <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_instr    <= NOP_INSTR;
        end else if (load_bubble) begin
            if_id_valid    <= 1'b0;
            if_id_pc       <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_instr    <= NOP_INSTR;
        end else if (do_fetch) begin
            if_id_valid    <= 1'b1;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_instr    <= imem_rdata;
        end
    end

    // Saturating: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (do_fetch && (fetch_count != '1)) begin
            fetch_count <= fetch_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed steps plus random stall/redirect
// traffic against a transaction-level fetch model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        halted;
    logic [15:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rom [0:127];

    logic        m_valid;
    logic [31:0] m_pc, m_ipc, m_ip4, m_instr;
    logic        m_halted;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    // Image: words 0..73 nonzero, 296..511 zero, beyond that a nonzero stub.
    function automatic logic [31:0] rom_rd(input logic [31:0] a);
        if (a < 32'd296) return rom[a[8:2]];
        if (a < 32'd512) return 32'h0;
        return a ^ 32'h5a5a5a5a;
    endfunction

    assign imem_rdata = rom_rd(imem_addr);

    if_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
        .halted(halted), .fetch_count(fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_ip4 = 32'h0;
        m_instr = 32'h13; m_halted = 1'b0; m_cnt = 16'h0;
    endtask

    task automatic bubble();
        m_valid = 1'b0; m_ipc = 32'h0; m_ip4 = 32'h0; m_instr = 32'h13;
    endtask

    task automatic model_edge();
        logic [31:0] w;
        if (redirect_valid) begin
            m_pc = redirect_pc & 32'hFFFFFFFC;
            bubble();
            m_halted = 1'b0;
        end else if (stall) begin
        end else if (m_halted) begin
            bubble();
        end else begin
            w = rom_rd(m_pc);
            if (w == 32'h0) begin
                bubble();
                m_halted = 1'b1;
            end else begin
                m_valid = 1'b1; m_ipc = m_pc; m_ip4 = m_pc + 32'd4;
                m_instr = w; m_pc = m_pc + 32'd4;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
    endtask

    task automatic check_all();
        check("imem_addr", imem_addr, m_pc);
        check("valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        check("if_id_pc", if_id_pc, m_ipc);
        check("pc_plus4", if_id_pc_plus4, m_ip4);
        check("instr", if_id_instr, m_instr);
        check("halted", {31'h0, halted}, {31'h0, m_halted});
        check("fetch_count", {16'h0, fetch_count}, {16'h0, m_cnt});
    endtask

    task automatic step(input bit chk);
        @(posedge clk);
        model_edge();
        #1;
        if (chk) check_all();
    endtask

    // Called at posedge+1: reset lands mid-cycle, released before next edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = $urandom | 32'h1;
        rom[0]  = 32'h00100f93;
        rom[1]  = 32'h01f02023;
        rom[4]  = 32'h00900f93;
        rom[5]  = 32'h01f02223;
        rom[13] = 32'hfd010113;
        model_reset();

        #12 check_all();
        rst_n = 1'b1;

        step(1);
        check("first_pc", if_id_pc, 32'h0);
        check("first_instr", if_id_instr, 32'h00100f93);
        step(1);
        check("second_addr", imem_addr, 32'h8);
        check("second_instr", if_id_instr, 32'h01f02023);
        for (int i = 0; i < 3; i++) step(1);
        check("pre_stall_pc", if_id_pc, 32'd16);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("stall_addr", imem_addr, 32'd20);
            check("stall_instr", if_id_instr, 32'h00900f93);
        end
        stall = 1'b0;
        step(1);
        check("unstall_pc", if_id_pc, 32'd20);
        check("unstall_instr", if_id_instr, 32'h01f02223);

        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h34;
        step(1);
        check("redir_addr", imem_addr, 32'h34);
        check("redir_instr", if_id_instr, 32'h13);
        stall = 1'b0; redirect_valid = 1'b0;
        step(1);
        check("redir_fetch", if_id_instr, 32'hfd010113);

        do_reset();
        for (int i = 0; i < 200 && !halted; i++) step(1);
        check("halt_flag", {31'h0, halted}, 32'h1);
        check("halt_count", {16'h0, fetch_count}, 32'd74);
        check("halt_addr", imem_addr, 32'd296);
        step(1);
        step(1);
        check("halt_bubble", {31'h0, if_id_valid}, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step(1);
        check("unhalt", {31'h0, halted}, 32'h0);
        redirect_valid = 1'b0;
        step(1);
        check("refetch", if_id_instr, 32'h00100f93);

        redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF;
        step(1);
        check("wrap_addr", imem_addr, 32'hFFFFFFFC);
        redirect_valid = 1'b0;
        step(1);
        check("wrap_next", imem_addr, 32'h0);
        check("wrap_p4", if_id_pc_plus4, 32'h0);

        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom
                        : 32'($urandom_range(0, 600));
            step(1);
        end

        stall = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h1000;
        step(1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 65600; i++) step(0);
        check_all();
        check("saturate", {16'h0, fetch_count}, 32'hFFFF);

        redirect_valid = 1'b1; redirect_pc = 32'd296;
        step(1);
        redirect_valid = 1'b0;
        step(1);
        stall = 1'b1;
        step(1);
        check("pre_areset", {31'h0, halted}, 32'h1);
        do_reset();
        stall = 1'b0;
        step(1);
        check("post_reset", if_id_instr, 32'h00100f93);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
